// File: rtl/nco_phase_sine_if.sv
// Tuning-word handshake, divided sample clock and sample outputs of the NCO core.
// master drives the tuning word and sample clock; slave is the NCO itself.
interface nco_phase_sine_if #(
  parameter int PHASE_WIDTH = 24,
  parameter int AMP_WIDTH   = 12
);
  logic                        sample_clk_in;
  logic [PHASE_WIDTH-1:0]      ftw_in;
  logic                        ftw_valid;
  logic                        ftw_ready;
  logic [PHASE_WIDTH-1:0]      phase_out;
  logic signed [AMP_WIDTH-1:0] sine_out;
  logic                        sine_valid;

  modport master (
    output sample_clk_in, ftw_in, ftw_valid,
    input  ftw_ready, phase_out, sine_out, sine_valid
  );

  modport slave (
    input  sample_clk_in, ftw_in, ftw_valid,
    output ftw_ready, phase_out, sine_out, sine_valid
  );
endinterface

// File: rtl/nco_phase_sine.sv
// NCO: edge-detected sample clock advances a phase accumulator; quarter-wave LUT gives a signed sine 3 cycles later.
// Optional LUT-address dither with a 16-bit LFSR when NCO_PHASE_DITHER_EN is defined.
module nco_phase_sine #(
  parameter int PHASE_WIDTH    = 24,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int AMP_WIDTH      = 12
) (
  input  logic            clk_in,
  input  logic            rst,
  nco_phase_sine_if.slave bus
);
  localparam int LUT_DEPTH = 32'd1 << LUT_ADDR_WIDTH;
  localparam int MAG_WIDTH = AMP_WIDTH - 1;
  localparam int TOP_WIDTH = LUT_ADDR_WIDTH + 2;

  typedef logic [PHASE_WIDTH-1:0] phase_t;
  typedef logic [MAG_WIDTH-1:0]   mag_t;

  // Sample i sits at the centre of its bin, so the table never hits zero or needs a duplicate peak.
  function automatic mag_t lut_entry(input int i);
    real amp;
    real ang;
    amp = (2.0 ** (AMP_WIDTH - 1)) - 1.0;
    ang = 3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / (2.0 ** LUT_ADDR_WIDTH);
    return mag_t'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  mag_t lut_rom [LUT_DEPTH];
  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
    assign lut_rom[g] = lut_entry(g);
  end

  logic   sample_prev_q, sample_prev_d;
  phase_t phase_q, phase_d;
  phase_t active_ftw_q, active_ftw_d;
  phase_t pending_ftw_q, pending_ftw_d;
  logic   pending_full_q, pending_full_d;
  logic   sample_event;
  logic   ftw_take;

  logic   stage1_valid_q, stage1_valid_d;
  logic   stage2_valid_q, stage2_valid_d;
  mag_t   lut_mag_q, lut_mag_d;
  logic   negate_q, negate_d;
  logic   sine_valid_q, sine_valid_d;
  logic signed [AMP_WIDTH-1:0] sine_out_q, sine_out_d;
  logic signed [AMP_WIDTH-1:0] sine_mag;

  logic [TOP_WIDTH-1:0]      lut_top;
  logic [1:0]                quadrant;
  logic [LUT_ADDR_WIDTH-1:0] lut_idx;

  // A pending word is only consumed by an event; a capture in the same cycle waits for the next one.
  always_comb begin
    sample_event   = bus.sample_clk_in & ~sample_prev_q;
    ftw_take       = bus.ftw_valid & ~pending_full_q;
    sample_prev_d  = bus.sample_clk_in;
    phase_d        = phase_q;
    active_ftw_d   = active_ftw_q;
    pending_ftw_d  = pending_ftw_q;
    pending_full_d = pending_full_q;
    if (sample_event) begin
      if (pending_full_q) begin
        phase_d        = phase_q + pending_ftw_q;
        active_ftw_d   = pending_ftw_q;
        pending_full_d = 1'b0;
      end else begin
        phase_d        = phase_q + active_ftw_q;
      end
    end else begin
      phase_d = phase_q;
    end
    if (ftw_take) begin
      pending_ftw_d  = bus.ftw_in;
      pending_full_d = 1'b1;
    end else begin
      pending_ftw_d  = pending_ftw_q;
    end
  end

`ifdef NCO_PHASE_DITHER_EN
  localparam int LOW_WIDTH   = PHASE_WIDTH - TOP_WIDTH;
  localparam int DITHER_W    = (LOW_WIDTH < 16) ? LOW_WIDTH : 16;
  localparam logic [15:0] DITHER_MASK = 16'((32'd1 << DITHER_W) - 32'd1);

  logic [15:0]          lfsr_q, lfsr_d;
  logic [LOW_WIDTH-1:0] dither_low;
  logic                 dither_carry;

  // Only the carry of the dither into the LUT-address bits matters, so no full-width sum is built.
  always_comb begin
    if (sample_event) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end else begin
      lfsr_d = lfsr_q;
    end
    dither_low   = LOW_WIDTH'(lfsr_q & DITHER_MASK);
    dither_carry = (dither_low > ~phase_q[LOW_WIDTH-1:0]);
    lut_top      = phase_q[PHASE_WIDTH-1 -: TOP_WIDTH] + {{(TOP_WIDTH-1){1'b0}}, dither_carry};
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  always_comb begin
    lut_top = phase_q[PHASE_WIDTH-1 -: TOP_WIDTH];
  end
`endif

  // Quarter-wave fold: odd quadrants mirror the index, the upper half-cycle negates.
  always_comb begin
    quadrant       = lut_top[TOP_WIDTH-1 -: 2];
    if (quadrant[0]) begin
      lut_idx = ~lut_top[LUT_ADDR_WIDTH-1:0];
    end else begin
      lut_idx = lut_top[LUT_ADDR_WIDTH-1:0];
    end
    stage1_valid_d = sample_event;
    stage2_valid_d = stage1_valid_q;
    sine_valid_d   = stage2_valid_q;
    if (stage1_valid_q) begin
      lut_mag_d = lut_rom[lut_idx];
      negate_d  = quadrant[1];
    end else begin
      lut_mag_d = lut_mag_q;
      negate_d  = negate_q;
    end
    sine_mag = {1'b0, lut_mag_q};
    if (stage2_valid_q) begin
      sine_out_d = negate_q ? -sine_mag : sine_mag;
    end else begin
      sine_out_d = sine_out_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sample_prev_q  <= 1'b1;
      phase_q        <= '0;
      active_ftw_q   <= '0;
      pending_ftw_q  <= '0;
      pending_full_q <= 1'b0;
      stage1_valid_q <= 1'b0;
      stage2_valid_q <= 1'b0;
      lut_mag_q      <= '0;
      negate_q       <= 1'b0;
      sine_valid_q   <= 1'b0;
      sine_out_q     <= '0;
    end else begin
      sample_prev_q  <= sample_prev_d;
      phase_q        <= phase_d;
      active_ftw_q   <= active_ftw_d;
      pending_ftw_q  <= pending_ftw_d;
      pending_full_q <= pending_full_d;
      stage1_valid_q <= stage1_valid_d;
      stage2_valid_q <= stage2_valid_d;
      lut_mag_q      <= lut_mag_d;
      negate_q       <= negate_d;
      sine_valid_q   <= sine_valid_d;
      sine_out_q     <= sine_out_d;
    end
  end

  assign bus.ftw_ready  = ~pending_full_q;
  assign bus.phase_out  = phase_q;
  assign bus.sine_out   = sine_out_q;
  assign bus.sine_valid = sine_valid_q;
endmodule

// File: tb/tb_nco_phase_sine.sv
// Self-checking bench for nco_phase_sine: directed scenarios plus randomized traffic against a behavioural model.
module tb_nco_phase_sine;
  localparam int PW  = 24;
  localparam int LAW = 8;
  localparam int AW  = 12;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  nco_phase_sine_if #(.PHASE_WIDTH(PW), .AMP_WIDTH(AW)) bus ();

  nco_phase_sine #(.PHASE_WIDTH(PW), .LUT_ADDR_WIDTH(LAW), .AMP_WIDTH(AW)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  // behavioural model state
  logic [PW-1:0] m_phase, m_active, m_pending;
  bit            m_pfull, m_prev;
  int            m_sine;
  bit            pv [3];
  int            ps [3];

  function automatic int ref_sine(input logic [PW-1:0] ph);
    longint p;
    int quad, idx, mag;
    real r;
    p    = longint'(ph);
    quad = int'(p / (64'd1 << (PW - 2)));
    idx  = int'((p / (64'd1 << (PW - 2 - LAW))) % (64'd1 << LAW));
    if (quad % 2 == 1) idx = (1 << LAW) - 1 - idx;
    r    = ((2.0 ** (AW - 1)) - 1.0) * $sin(3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / (2.0 ** LAW));
    mag  = $rtoi(r + 0.5);
    return (quad >= 2) ? -mag : mag;
  endfunction

  task automatic reset_model();
    m_phase = '0; m_active = '0; m_pending = '0;
    m_pfull = 1'b0; m_prev = 1'b1; m_sine = 0;
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; ps[i] = 0; end
  endtask

  // advance model by one clock with the inputs currently driven, then move to 1 time unit after the edge
  task automatic model_tick();
    bit ev, cap;
    ev  = bus.sample_clk_in && !m_prev;
    cap = bus.ftw_valid && !m_pfull;
    m_prev = bus.sample_clk_in;
    if (ev) begin
      m_phase = m_phase + (m_pfull ? m_pending : m_active);
      if (m_pfull) begin m_active = m_pending; m_pfull = 1'b0; end
    end
    if (cap) begin m_pending = bus.ftw_in; m_pfull = 1'b1; end
    pv[2] = pv[1]; ps[2] = ps[1];
    pv[1] = pv[0]; ps[1] = ps[0];
    pv[0] = ev;    ps[0] = ref_sine(m_phase);
    if (pv[2]) m_sine = ps[2];
    @(posedge clk_in); #1;
    if (cap) bus.ftw_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.sample_clk_in = 1'b1; bus.ftw_valid = 1'b0; bus.ftw_in = '0;
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      checks += 4;
      if (bus.phase_out !== 24'h000000) begin failures++; $display("FAIL reset_phase got=%h want=000000", bus.phase_out); end
      if (bus.sine_out !== 12'sd0) begin failures++; $display("FAIL reset_sine got=%0d want=0", $signed(bus.sine_out)); end
      if (bus.sine_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.sine_valid); end
      if (bus.ftw_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.ftw_ready); end
    end
    reset_model();
    rst = 1'b0;
    // sample clock already high at release must not count as an event
    for (int i = 0; i < 5; i++) begin
      model_tick();
      checks += 2;
      if (bus.phase_out !== 24'h000000) begin failures++; $display("FAIL release_high_phase got=%h want=000000", bus.phase_out); end
      if (bus.sine_valid !== 1'b0) begin failures++; $display("FAIL release_high_valid got=%b want=0", bus.sine_valid); end
    end
    bus.sample_clk_in = 1'b0;
    model_tick();
  endtask

  task automatic test_quarter_steps();
    logic [PW-1:0] exp_phase [4];
    int exp_sine [4];
    exp_phase = '{24'h400000, 24'h800000, 24'hC00000, 24'h000000};
    exp_sine  = '{2047, -6, -2047, 6};
    bus.ftw_in = 24'h400000; bus.ftw_valid = 1'b1;
    model_tick();
    checks++;
    if (bus.ftw_ready !== 1'b0) begin failures++; $display("FAIL quarter_ready_after_capture got=%b want=0", bus.ftw_ready); end
    for (int k = 0; k < 4; k++) begin
      bus.sample_clk_in = 1'b1; model_tick();
      checks += 2;
      if (bus.phase_out !== exp_phase[k]) begin failures++; $display("FAIL quarter_phase[%0d] got=%h want=%h", k, bus.phase_out, exp_phase[k]); end
      if (bus.sine_valid !== 1'b0) begin failures++; $display("FAIL quarter_early_valid1[%0d] got=%b want=0", k, bus.sine_valid); end
      if (k == 0) begin
        checks++;
        if (bus.ftw_ready !== 1'b1) begin failures++; $display("FAIL quarter_ready_after_event got=%b want=1", bus.ftw_ready); end
      end
      bus.sample_clk_in = 1'b0; model_tick();
      checks++;
      if (bus.sine_valid !== 1'b0) begin failures++; $display("FAIL quarter_early_valid2[%0d] got=%b want=0", k, bus.sine_valid); end
      model_tick();
      checks += 2;
      if (bus.sine_valid !== 1'b1) begin failures++; $display("FAIL quarter_strobe[%0d] got=%b want=1", k, bus.sine_valid); end
      if (bus.sine_out !== AW'(exp_sine[k])) begin failures++; $display("FAIL quarter_sine[%0d] got=%0d want=%0d", k, $signed(bus.sine_out), exp_sine[k]); end
      model_tick();
      checks += 2;
      if (bus.sine_valid !== 1'b0) begin failures++; $display("FAIL quarter_strobe_width[%0d] got=%b want=0", k, bus.sine_valid); end
      if (bus.sine_out !== AW'(exp_sine[k])) begin failures++; $display("FAIL quarter_hold[%0d] got=%0d want=%0d", k, $signed(bus.sine_out), exp_sine[k]); end
    end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] exp_phase [3];
    exp_phase = '{24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD};
    bus.ftw_in = 24'hFFFFFF; bus.ftw_valid = 1'b1;
    model_tick();
    for (int k = 0; k < 3; k++) begin
      bus.sample_clk_in = 1'b1; model_tick();
      checks++;
      if (bus.phase_out !== exp_phase[k]) begin failures++; $display("FAIL wrap_phase[%0d] got=%h want=%h", k, bus.phase_out, exp_phase[k]); end
      bus.sample_clk_in = 1'b0; model_tick(); model_tick();
      checks += 2;
      if (bus.sine_valid !== 1'b1) begin failures++; $display("FAIL wrap_strobe[%0d] got=%b want=1", k, bus.sine_valid); end
      if (bus.sine_out !== AW'(ref_sine(exp_phase[k]))) begin failures++; $display("FAIL wrap_sine[%0d] got=%0d want=%0d", k, $signed(bus.sine_out), ref_sine(exp_phase[k])); end
    end
    model_tick();
  endtask

  task automatic test_back_pressure();
    logic [PW-1:0] a, b, p0, exp1, exp2;
    a = PW'($urandom); b = PW'($urandom); p0 = m_phase;
    exp1 = p0 + a; exp2 = exp1 + b;
    bus.ftw_in = a; bus.ftw_valid = 1'b1;
    model_tick();
    bus.ftw_in = b; bus.ftw_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_tick();
      checks++;
      if (bus.ftw_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low[%0d] got=%b want=0", i, bus.ftw_ready); end
    end
    bus.sample_clk_in = 1'b1; model_tick();
    checks += 2;
    if (bus.phase_out !== exp1) begin failures++; $display("FAIL bp_uses_a got=%h want=%h", bus.phase_out, exp1); end
    if (bus.ftw_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_rise got=%b want=1", bus.ftw_ready); end
    bus.sample_clk_in = 1'b0; model_tick();
    checks++;
    if (bus.ftw_ready !== 1'b0) begin failures++; $display("FAIL bp_b_captured got=%b want=0", bus.ftw_ready); end
    model_tick(); model_tick();
    bus.sample_clk_in = 1'b1; model_tick();
    checks++;
    if (bus.phase_out !== exp2) begin failures++; $display("FAIL bp_uses_b got=%h want=%h", bus.phase_out, exp2); end
    bus.sample_clk_in = 1'b0;
    for (int i = 0; i < 3; i++) model_tick();
  endtask

  task automatic test_same_cycle_capture();
    logic [PW-1:0] c, old_ftw, p0, exp1, exp2;
    c = PW'($urandom); old_ftw = m_active; p0 = m_phase;
    exp1 = p0 + old_ftw; exp2 = exp1 + c;
    bus.sample_clk_in = 1'b1; bus.ftw_in = c; bus.ftw_valid = 1'b1;
    model_tick();
    checks += 2;
    if (bus.phase_out !== exp1) begin failures++; $display("FAIL same_cycle_old_ftw got=%h want=%h", bus.phase_out, exp1); end
    if (bus.ftw_ready !== 1'b0) begin failures++; $display("FAIL same_cycle_ready got=%b want=0", bus.ftw_ready); end
    bus.sample_clk_in = 1'b0; model_tick(); model_tick();
    bus.sample_clk_in = 1'b1; model_tick();
    checks++;
    if (bus.phase_out !== exp2) begin failures++; $display("FAIL same_cycle_new_ftw got=%h want=%h", bus.phase_out, exp2); end
    bus.sample_clk_in = 1'b0;
    for (int i = 0; i < 3; i++) model_tick();
  endtask

  task automatic test_held_high();
    logic [PW-1:0] exp_phase;
    int pulses;
    pulses = 0;
    exp_phase = m_phase + m_active;
    bus.sample_clk_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      model_tick();
      if (bus.sine_valid === 1'b1) pulses++;
      checks++;
      if (bus.phase_out !== exp_phase) begin failures++; $display("FAIL held_phase[%0d] got=%h want=%h", i, bus.phase_out, exp_phase); end
    end
    bus.sample_clk_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model_tick();
      if (bus.sine_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL held_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.sample_clk_in = 1'($urandom_range(0, 1));
      if (!bus.ftw_valid && $urandom_range(0, 3) == 0) begin
        bus.ftw_in = PW'($urandom); bus.ftw_valid = 1'b1;
      end
      model_tick();
      checks += 4;
      if (bus.phase_out !== m_phase) begin failures++; $display("FAIL rand_phase[%0d] got=%h want=%h", i, bus.phase_out, m_phase); end
      if (bus.sine_valid !== pv[2]) begin failures++; $display("FAIL rand_valid[%0d] got=%b want=%b", i, bus.sine_valid, pv[2]); end
      if (bus.sine_out !== AW'(m_sine)) begin failures++; $display("FAIL rand_sine[%0d] got=%0d want=%0d", i, $signed(bus.sine_out), m_sine); end
      if (bus.ftw_ready !== !m_pfull) begin failures++; $display("FAIL rand_ready[%0d] got=%b want=%b", i, bus.ftw_ready, !m_pfull); end
    end
    bus.ftw_valid = 1'b0; bus.sample_clk_in = 1'b0;
    for (int i = 0; i < 4; i++) model_tick();
  endtask

  task automatic test_reset_midstream();
    bit pat [12];
    int pulses;
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pulses = 0;
    bus.ftw_in = PW'($urandom) | 24'h100000; bus.ftw_valid = 1'b1;
    model_tick();
    bus.sample_clk_in = 1'b1; model_tick();
    bus.sample_clk_in = 1'b0; bus.ftw_in = PW'($urandom); bus.ftw_valid = 1'b1;
    model_tick();
    // pending word held and a sample still in flight when reset hits mid-cycle
    #3 rst = 1'b1;
    #1;
    checks += 4;
    if (bus.phase_out !== 24'h000000) begin failures++; $display("FAIL mid_reset_phase got=%h want=000000", bus.phase_out); end
    if (bus.sine_out !== 12'sd0) begin failures++; $display("FAIL mid_reset_sine got=%0d want=0", $signed(bus.sine_out)); end
    if (bus.sine_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b want=0", bus.sine_valid); end
    if (bus.ftw_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b want=1", bus.ftw_ready); end
    bus.ftw_valid = 1'b0; bus.sample_clk_in = 1'b1;
    @(posedge clk_in); #1;
    checks++;
    if (bus.sine_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_inflight got=%b want=0", bus.sine_valid); end
    reset_model();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.sample_clk_in = pat[i];
      model_tick();
      if (bus.sine_valid === 1'b1) pulses++;
      checks += 3;
      if (bus.phase_out !== m_phase) begin failures++; $display("FAIL post_reset_phase[%0d] got=%h want=%h", i, bus.phase_out, m_phase); end
      if (bus.sine_valid !== pv[2]) begin failures++; $display("FAIL post_reset_valid[%0d] got=%b want=%b", i, bus.sine_valid, pv[2]); end
      if (bus.sine_out !== AW'(m_sine)) begin failures++; $display("FAIL post_reset_sine[%0d] got=%0d want=%0d", i, $signed(bus.sine_out), m_sine); end
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL post_reset_pulses got=%0d want=1", pulses); end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_quarter_steps();
    test_wrap();
    test_back_pressure();
    test_same_cycle_capture();
    test_held_high();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
